// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t           : access sequencer states
//   REQ_FETCH/REQ_DATA: requester ids (instruction fetch / load-store)
//   MAX_WAIT          : largest supported number of memory wait states
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAITST = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int MAX_WAIT = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req0, req1 : request lines (fetch, data)
//   last       : id of the previously granted requester
//   valid      : at least one request pending
//   winner     : id of the requester to serve next
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      // On a tie, serve whoever was not served last time.
      winner = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else begin
      winner = req1 ? REQ_DATA : REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch path (requester 0,
// read-only) and the load/store path (requester 1). Requests are sampled
// in IDLE, the winner's request is latched, and the access is sequenced
// through WAIT wait states before a one-cycle done pulse.
//   clk, reset            : clock, asynchronous active-low reset
//   req0, addr0           : fetch request and address
//   req1, we1, addr1,
//   wdata1                : data request, write flag, address, write value
//   gnt0, gnt1            : request accepted (one-cycle pulse)
//   done0, done1          : access complete (one-cycle pulse)
//   rdata                 : read data, updated only when a read completes
//   busy                  : an access is in progress
//   mem_en, mem_we,
//   mem_addr, mem_wdata   : memory strobe, write enable, address, data
//   mem_rdata             : memory read data, valid on last access cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WAIT_C = (WAIT > MAX_WAIT) ? MAX_WAIT : WAIT;
  localparam int CW     = (WAIT_C < 1) ? 1 : $clog2(WAIT_C + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_C > 0) ? WAIT_C - 1 : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          arb_valid;
  logic          arb_winner;
  logic          access_last;

  rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .valid (arb_valid),
    .winner(arb_winner)
  );

  // Next state and Moore outputs. Outputs depend only on registered state,
  // so reset clears them immediately and mid-access reset drops mem_en/we.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        gnt0      = (id_q == REQ_FETCH);
        gnt1      = (id_q == REQ_DATA);
        state_nxt = (WAIT_C == 0) ? RESP : WAITST;
      end
      WAITST: begin
        mem_en = 1'b1;
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        done0     = (id_q == REQ_FETCH);
        done1     = (id_q == REQ_DATA);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final ACCESS/WAITST cycle is the one leaving for RESP.
  assign access_last = mem_en && (state_nxt == RESP);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state here is a handful of flops, not a memory array, so
    // everything is reset to give the documented all-zero outputs.
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= REQ_FETCH;
      id_q    <= REQ_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;

      if (state == IDLE && arb_valid) begin
        id_q   <= arb_winner;
        last   <= arb_winner;
        // The fetch path is read-only, whatever we1 says.
        we_q   <= (arb_winner == REQ_DATA) && we1;
        addr_q <= (arb_winner == REQ_DATA) ? addr1 : addr0;
        if (arb_winner == REQ_DATA) wdata_q <= wdata1;
      end

      // Loaded only from ACCESS and stops at zero, so it never wraps.
      if (state == ACCESS) begin
        cnt <= CNT_LOAD;
      end else if (state == WAITST && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (access_last && !we_q) rdata_q <= mem_rdata;
    end
  end

  assign busy      = (state != IDLE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Three instances (WAIT = 0, 1, 7)
// share one stimulus stream; a timeline model per instance predicts every
// output from the request start cycle and the arbitration rule.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 7);
  endfunction

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata1, mem_rdata;

  logic          gnt0_o     [NI];
  logic          gnt1_o     [NI];
  logic          done0_o    [NI];
  logic          done1_o    [NI];
  logic          busy_o     [NI];
  logic          mem_en_o   [NI];
  logic          mem_we_o   [NI];
  logic [DW-1:0] rdata_o    [NI];
  logic [AW-1:0] mem_addr_o [NI];
  logic [DW-1:0] mem_wdata_o[NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(wait_of(k))) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .addr0    (addr0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .gnt0     (gnt0_o[k]),
      .gnt1     (gnt1_o[k]),
      .done0    (done0_o[k]),
      .done1    (done1_o[k]),
      .rdata    (rdata_o[k]),
      .busy     (busy_o[k]),
      .mem_en   (mem_en_o[k]),
      .mem_we   (mem_we_o[k]),
      .mem_addr (mem_addr_o[k]),
      .mem_wdata(mem_wdata_o[k]),
      .mem_rdata(mem_rdata)
    );
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: one access record per instance, described by the cycle
  // its request was sampled in; all outputs follow from offsets to it.
  int            cyc = 0;
  bit            have_acc[NI];
  int            s_m     [NI];
  bit            id_m    [NI];
  bit            we_m    [NI];
  bit            last_m  [NI];
  logic [AW-1:0] addr_m  [NI];
  logic [DW-1:0] wdata_m [NI];
  logic [DW-1:0] rdata_m [NI];

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (WAIT=%0d, cycle %0d): got %0h expected %0h",
               name, wait_of(k), cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      have_acc[k] = 1'b0;
      s_m[k]      = 0;
      id_m[k]     = 1'b0;
      we_m[k]     = 1'b0;
      last_m[k]   = 1'b0;
      addr_m[k]   = '0;
      wdata_m[k]  = '0;
      rdata_m[k]  = '0;
    end
  endtask

  // Called just before a rising edge with the inputs the DUT is about to see.
  task automatic model_edge();
    int p;
    int w;
    bit win;
    p = cyc;
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        w = wait_of(k);
        // Cycle s+1+w is the last access cycle: reads capture mem_rdata.
        if (have_acc[k] && p == s_m[k] + 1 + w && !we_m[k]) rdata_m[k] = mem_rdata;
        // Idle unless the current cycle lies in the busy window s+1 .. s+2+w.
        if (!(have_acc[k] && p >= s_m[k] + 1 && p <= s_m[k] + 2 + w) && (req0 || req1)) begin
          win         = (req0 && req1) ? !last_m[k] : req1;
          have_acc[k] = 1'b1;
          s_m[k]      = p;
          id_m[k]     = win;
          last_m[k]   = win;
          we_m[k]     = win && we1;
          addr_m[k]   = win ? addr1 : addr0;
          if (win) wdata_m[k] = wdata1;
        end
      end
    end
    cyc++;
  endtask

  // {gnt0, gnt1, done0, done1, busy, mem_en, mem_we} expected for this cycle.
  function automatic logic [6:0] exp_ctl(input int k);
    int  w;
    int  s;
    bit  en;
    bit  bsy;
    w = wait_of(k);
    s = s_m[k];
    if (!have_acc[k]) return '0;
    en  = (cyc >= s + 1) && (cyc <= s + 1 + w);
    bsy = (cyc >= s + 1) && (cyc <= s + 2 + w);
    return {cyc == s + 1 && !id_m[k], cyc == s + 1 && id_m[k],
            cyc == s + 2 + w && !id_m[k], cyc == s + 2 + w && id_m[k],
            bsy, en, en && we_m[k]};
  endfunction

  function automatic logic [6:0] act_ctl(input int k);
    return {gnt0_o[k], gnt1_o[k], done0_o[k], done1_o[k],
            busy_o[k], mem_en_o[k], mem_we_o[k]};
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check("ctl{gnt0,gnt1,done0,done1,busy,en,we}", k, 64'(act_ctl(k)), 64'(exp_ctl(k)));
      check("mem_addr", k, 64'(mem_addr_o[k]), 64'(addr_m[k]));
      check("mem_wdata", k, 64'(mem_wdata_o[k]), 64'(wdata_m[k]));
      check("rdata", k, 64'(rdata_o[k]), 64'(rdata_m[k]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rstep();
    mem_rdata = $urandom();
    step();
  endtask

  task automatic drain();
    req0 = 1'b0;
    req1 = 1'b0;
    we1  = 1'b0;
    repeat (12) rstep();
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  typedef struct {
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] mrd;
    logic [6:0]    ctl;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vt[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int en_cnt;
    int done_at;
    int n_bad;
    int gnt_cyc[$];
    bit gnt_id[$];
    bit exp_order[4];

    // Fetch read on the WAIT=1 instance, one row per clock edge.
    vt[0] = '{1'b1, 32'h10, 32'h2222_2222, 7'b100_0110, 32'h10, 32'h0};
    vt[1] = '{1'b0, 32'h10, 32'h1111_1111, 7'b000_0110, 32'h10, 32'h0};
    vt[2] = '{1'b0, 32'h10, 32'hE3A0_0001, 7'b001_0100, 32'h10, 32'hE3A0_0001};
    vt[3] = '{1'b0, 32'h10, 32'h3333_3333, 7'b000_0000, 32'h10, 32'hE3A0_0001};
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset     = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    we1       = 1'b0;
    addr0     = '0;
    addr1     = '0;
    wdata1    = '0;
    mem_rdata = '0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    reset = 1'b1;
    step();

    // Table: fetch on WAIT=1.
    for (int i = 0; i < 4; i++) begin
      req0      = vt[i].req0;
      addr0     = vt[i].addr0;
      mem_rdata = vt[i].mrd;
      step();
      check("table ctl", 1, 64'(act_ctl(1)), 64'(vt[i].ctl));
      check("table mem_addr", 1, 64'(mem_addr_o[1]), 64'(vt[i].addr));
      check("table rdata", 1, 64'(rdata_o[1]), 64'(vt[i].rdata));
    end
    drain();

    // Data write on WAIT=0: one-cycle strobe, done at t+2, rdata untouched.
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 32'h40;
    wdata1 = 32'hDEAD_BEEF;
    rstep();
    req1 = 1'b0;
    we1  = 1'b0;
    check("wr gnt1/mem_we", 0, 64'({gnt1_o[0], mem_we_o[0]}), 64'b11);
    check("wr mem_addr", 0, 64'(mem_addr_o[0]), 64'h40);
    check("wr mem_wdata", 0, 64'(mem_wdata_o[0]), 64'hDEAD_BEEF);
    rstep();
    check("wr done1/mem_we", 0, 64'({done1_o[0], mem_we_o[0]}), 64'b10);
    rstep();
    check("wr rdata held", 0, 64'(rdata_o[0]), 64'h1111_1111);
    drain();

    // Both requesters held from reset: alternate 1,0,1,0 every 3+WAIT.
    async_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 32'h100;
    addr1 = 32'h200;
    rstep();
    reset = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 40; i++) begin
      rstep();
      for (int k = 0; k < NI; k++) if (gnt0_o[k] && gnt1_o[k]) n_bad++;
      if (gnt0_o[1] || gnt1_o[1]) begin
        gnt_cyc.push_back(cyc);
        gnt_id.push_back(gnt1_o[1]);
      end
    end
    check("two gnts in one cycle", 1, 64'(n_bad), 64'd0);
    check("grants seen >= 4", 1, 64'(gnt_id.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < gnt_id.size(); i++) begin
      check("grant order", 1, 64'(gnt_id[i]), 64'(exp_order[i]));
      if (i > 0) check("grant spacing", 1, 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd4);
    end
    drain();

    // WAIT=7 read: 8 strobe cycles, done at t+9, address stable.
    t0      = cyc;
    en_cnt  = 0;
    done_at = -1;
    req0    = 1'b1;
    addr0   = 32'h80;
    for (int i = 0; i < 14; i++) begin
      rstep();
      req0 = 1'b0;
      if (mem_en_o[2]) begin
        en_cnt++;
        check("w7 mem_addr", 2, 64'(mem_addr_o[2]), 64'h80);
      end
      if (done0_o[2]) done_at = cyc;
    end
    check("w7 mem_en cycles", 2, 64'(en_cnt), 64'd8);
    check("w7 done latency", 2, 64'(done_at - t0), 64'd9);
    drain();

    // Reset during WAITST of a write on WAIT=7.
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 32'h44;
    wdata1 = 32'h5555_AAAA;
    rstep();
    req1 = 1'b0;
    we1  = 1'b0;
    rstep();
    rstep();
    check("w7 writing before reset", 2, 64'(mem_we_o[2]), 64'd1);
    async_reset();
    check("reset drops en/we", 2, 64'({mem_en_o[2], mem_we_o[2]}), 64'b00);
    rstep();
    reset = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      rstep();
      for (int k = 0; k < NI; k++) if (done0_o[k] || done1_o[k]) n_bad++;
    end
    check("done after reset", 2, 64'(n_bad), 64'd0);
    req0  = 1'b1;
    addr0 = 32'h20;
    rstep();
    req0 = 1'b0;
    check("gnt0 after reset", 2, 64'(gnt0_o[2]), 64'd1);
    drain();

    // One-cycle req1 pulse while busy is ignored.
    req0  = 1'b1;
    addr0 = 32'h30;
    rstep();
    req0  = 1'b0;
    req1  = 1'b1;
    addr1 = 32'h50;
    rstep();
    req1  = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 12; i++) begin
      rstep();
      for (int k = 0; k < NI; k++) if (gnt1_o[k] || done1_o[k]) n_bad++;
    end
    check("ignored req1 pulse", 0, 64'(n_bad), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we1    = $urandom_range(0, 1);
      addr0  = $urandom();
      addr1  = $urandom();
      wdata1 = $urandom();
      rstep();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
